// File: rtl/hazard_scoreboard_if.sv
// Purpose : ID-stage hazard bus between the pipeline control and the
//           hazard scoreboard.
// Signals : id_valid/id_rs1/id_rs2/id_rs*_used/id_rd/id_regwrite/
//           id_memread/id_muldiv - instruction currently held in ID
//           branch_taken - EX redirects this cycle
//           cnt_clr      - synchronous clear of the stall counter
//           stall/bubble/flush - pipeline control back to the core
//           md_busy/stall_cnt  - status
// Modports: master = pipeline side, slave = scoreboard side.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_muldiv;
    logic              branch_taken;
    logic              cnt_clr;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_muldiv, branch_taken, cnt_clr,
        input  stall, bubble, flush, md_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_muldiv, branch_taken, cnt_clr,
        output stall, bubble, flush, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose : Per-register pending-result scoreboard for an in-order pipeline.
//           Detects RAW hazards against in-flight loads / mul-div results,
//           structural hazards on the single mul/div unit, and converts a
//           taken branch into a flush that overrides any stall.
// Ports   : clk, rst_n (async, active-low)
//           bus (hazard_scoreboard_if.slave):
//             in : id_* instruction fields, branch_taken, cnt_clr
//             out: stall, bubble, flush (combinational from inputs and
//                  registered state), md_busy, stall_cnt (registered state)
module hazard_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);
    localparam int unsigned NREG = 1 << REG_AW;
    localparam int unsigned PW   = 3;
    localparam logic [PW-1:0] LD_LAT_C = PW'(LOAD_LAT);
    localparam logic [PW-1:0] MD_LAT_C = PW'(MD_LAT);

    logic [PW-1:0]    r_pend [NREG];
    logic [PW-1:0]    w_pend_nxt [NREG];
    logic [PW-1:0]    r_md_cnt;
    logic [PW-1:0]    w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;

    logic             w_raw;
    logic             w_struct;
    logic             w_stall;
    logic             w_issue;
    logic             w_load_rd;
    logic [PW-1:0]    w_new_lat;

    // RAW check against registered pend; x0 and unused sources never hazard.
    always_comb begin
        w_raw = 1'b0;
        if (bus.id_valid) begin
            if (bus.id_rs1_used && (bus.id_rs1 != '0) && (r_pend[bus.id_rs1] != '0))
                w_raw = 1'b1;
            if (bus.id_rs2_used && (bus.id_rs2 != '0) && (r_pend[bus.id_rs2] != '0))
                w_raw = 1'b1;
        end
    end

    assign w_struct = bus.id_valid & bus.id_muldiv & (r_md_cnt != '0);

    // A taken branch squashes the ID instruction, so it must not stall.
    assign w_stall  = (w_raw | w_struct) & ~bus.branch_taken;

    // Issue depends on stall, never the reverse: no loop through stall.
    assign w_issue   = bus.id_valid & ~w_stall & ~bus.branch_taken;
    assign w_load_rd = w_issue & bus.id_regwrite & (bus.id_rd != '0)
                     & (bus.id_memread | bus.id_muldiv);
    assign w_new_lat = bus.id_memread ? LD_LAT_C : MD_LAT_C;

    // Every entry counts down; the issuing rd takes max(decremented, new
    // latency) so an older, longer-latency writer is never shortened.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            w_pend_nxt[r] = (r_pend[r] != '0) ? (r_pend[r] - PW'(1)) : '0;
            if (w_load_rd && (bus.id_rd == REG_AW'(r)) && (w_new_lat > w_pend_nxt[r]))
                w_pend_nxt[r] = w_new_lat;
        end
    end

    // Structural occupancy of the mul/div unit.
    always_comb begin
        w_md_cnt_nxt = (r_md_cnt != '0) ? (r_md_cnt - PW'(1)) : '0;
        if (w_issue && bus.id_muldiv)
            w_md_cnt_nxt = MD_LAT_C;
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (bus.cnt_clr)
            w_stall_cnt_nxt = '0;
        else if (w_stall && (r_stall_cnt != '1))
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++)
                r_pend[r] <= '0;
            r_md_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                r_pend[r] <= w_pend_nxt[r];
            r_md_cnt    <= w_md_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.bubble    = w_stall | bus.branch_taken;
    assign bus.flush     = bus.branch_taken;
    assign bus.md_busy   = (r_md_cnt != '0);
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. The reference model tracks, per register,
// the absolute cycle at which its result becomes readable, and the cycle
// at which the mul/div unit frees up; hazards are "ready time in future".
module tb_hazard_scoreboard;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 4;
    localparam int unsigned LL   = 1;
    localparam int unsigned ML   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    hazard_scoreboard #(
        .REG_AW(AW), .LOAD_LAT(LL), .MD_LAT(ML), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ready_at [32];
    int md_free;
    int m_cnt;
    int cyc_n;
    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        md_free = 0;
        m_cnt   = 0;
    endtask

    function automatic logic m_pend(input int r);
        return (r != 0) && (ready_at[r] > cyc_n);
    endfunction

    task automatic drv(input logic v, input int rs1, input logic u1,
                       input int rs2, input logic u2, input int rd,
                       input logic rw, input logic mr, input logic md,
                       input logic bt, input logic clr);
        bus.id_valid     = v;
        bus.id_rs1       = AW'(rs1);
        bus.id_rs1_used  = u1;
        bus.id_rs2       = AW'(rs2);
        bus.id_rs2_used  = u2;
        bus.id_rd        = AW'(rd);
        bus.id_regwrite  = rw;
        bus.id_memread   = mr;
        bus.id_muldiv    = md;
        bus.branch_taken = bt;
        bus.cnt_clr      = clr;
    endtask

    task automatic nop();
        drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: check all outputs mid-cycle against the model, then advance it.
    task automatic cyc(output logic st);
        logic raw, strc, e_st, bt, issue;
        int lat, rd;
        @(negedge clk);
        bt   = bus.branch_taken;
        raw  = bus.id_valid && ((bus.id_rs1_used && m_pend(int'(bus.id_rs1))) ||
                                (bus.id_rs2_used && m_pend(int'(bus.id_rs2))));
        strc = bus.id_valid && bus.id_muldiv && (md_free > cyc_n);
        e_st = (raw || strc) && !bt;
        chk("stall",     32'(bus.stall),     32'(e_st));
        chk("bubble",    32'(bus.bubble),    32'(e_st || bt));
        chk("flush",     32'(bus.flush),     32'(bt));
        chk("md_busy",   32'(bus.md_busy),   32'(md_free > cyc_n));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        st    = bus.stall;
        issue = bus.id_valid && !e_st && !bt;
        rd    = int'(bus.id_rd);
        if (issue && bus.id_muldiv)
            md_free = cyc_n + 1 + int'(ML);
        if (issue && bus.id_regwrite && rd != 0 && (bus.id_memread || bus.id_muldiv)) begin
            lat = bus.id_memread ? int'(LL) : int'(ML);
            if (cyc_n + 1 + lat > ready_at[rd])
                ready_at[rd] = cyc_n + 1 + lat;
        end
        if (bus.cnt_clr)
            m_cnt = 0;
        else if (e_st && m_cnt < CMAX)
            m_cnt++;
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic idle(input int n);
        logic st;
        nop();
        for (int i = 0; i < n; i++) cyc(st);
    endtask

    // Holds the current inputs until the instruction issues (bounded).
    task automatic count_stalls(output int n);
        logic st;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(st);
            if (!st) break;
            n++;
        end
    endtask

    initial begin
        logic st;
        int   n;
        n_cmp = 0;
        n_bad = 0;
        cyc_n = 0;
        model_reset();

        // Reset: outputs quiet, flush still follows branch_taken.
        rst_n = 1'b0;
        nop();
        bus.branch_taken = 1'b1;
        #1;
        chk("rst_flush",   32'(bus.flush),     32'd1);
        chk("rst_bubble",  32'(bus.bubble),    32'd1);
        chk("rst_stall",   32'(bus.stall),     32'd0);
        chk("rst_md_busy", 32'(bus.md_busy),   32'd0);
        chk("rst_cnt",     32'(bus.stall_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nop();
        @(posedge clk);
        #1;

        // Load-use with LOAD_LAT=1: exactly one stall.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 5, 1'b1, 6, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(st);
        chk("ld_use_stall", 32'(st), 32'd1);
        cyc(st);
        chk("ld_use_release", 32'(st), 32'd0);
        chk("ld_use_cnt", 32'(bus.stall_cnt), 32'd1);
        idle(2);

        // Mul latency: dependent on rs2 stalls 4 cycles.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(st);
        chk("md_busy_after_mul", 32'(bus.md_busy), 32'd1);
        drv(1'b1, 1, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        count_stalls(n);
        chk("mul_raw_len", 32'(n), 32'd4);
        // Independent mul behind a mul: structural stall for 4 cycles.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 1, 1'b1, 2, 1'b1, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        count_stalls(n);
        chk("mul_struct_len", 32'(n), 32'd4);
        idle(6);

        // Flush wins over a stall; the squashed mul leaves no state behind.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 11, 1'b1, 2, 1'b1, 12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(st);
        chk("flush_no_stall", 32'(st), 32'd0);
        chk("flush_no_md", 32'(bus.md_busy), 32'd0);
        drv(1'b1, 12, 1'b1, 2, 1'b1, 13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(st);
        chk("flush_no_pend", 32'(st), 32'd0);
        // Older in-flight mul survives a flush.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 1, 1'b1, 2, 1'b1, 20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(st);
        drv(1'b1, 13, 1'b1, 2, 1'b1, 21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        count_stalls(n);
        chk("flush_keeps_old", 32'(n), 32'd3);
        idle(6);

        // x0 never pending; unused rs2 never stalls.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 0, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(st);
        chk("x0_no_stall", 32'(st), 32'd0);
        drv(1'b1, 1, 1'b1, 2, 1'b1, 14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 1, 1'b1, 14, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(st);
        chk("unused_rs2", 32'(st), 32'd0);
        idle(2);

        // WAW: short load behind a long mul keeps the longer wait.
        drv(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 3, 1'b1, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        count_stalls(n);
        chk("waw_len", 32'(n), 32'd3);
        idle(6);

        // Counter saturation, clear priority, and reset mid-stall.
        drv(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(st);
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 1, 1'b1, 2, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(st);
            drv(1'b1, 4, 1'b1, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            count_stalls(n);
        end
        chk("cnt_saturate", 32'(bus.stall_cnt), 32'd15);
        drv(1'b1, 1, 1'b1, 2, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(st);
        drv(1'b1, 4, 1'b1, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(st);
        chk("clr_over_inc", 32'(bus.stall_cnt), 32'd0);
        bus.cnt_clr = 1'b0;
        #1;
        chk("pre_reset_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall",   32'(bus.stall),     32'd0);
        chk("rst_mid_md_busy", 32'(bus.md_busy),   32'd0);
        chk("rst_mid_cnt",     32'(bus.stall_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(st);
        chk("post_reset_nopend", 32'(st), 32'd0);

        // Randomized traffic, small register window to provoke hazards.
        for (int k = 0; k < 500; k++) begin
            logic md, mr;
            md = ($urandom_range(0, 99) < 20);
            mr = !md && ($urandom_range(0, 99) < 35);
            drv($urandom_range(0, 99) < 85,
                int'($urandom_range(0, 7)), $urandom_range(0, 99) < 80,
                int'($urandom_range(0, 7)), $urandom_range(0, 99) < 70,
                int'($urandom_range(0, 7)), $urandom_range(0, 99) < 75,
                mr, md,
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 3);
            cyc(st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
